// File: rtl/digacc18_21.sv
// Residue-digit accumulator: sums bursts of up to MAX_TERMS residues into an unreduced partial sum.
// Optional range check on every accepted term is enabled by defining DIGACC_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | no group open; acc/cnt/err are zero
// ACCUM | group open; acc holds the partial sum of cnt terms
module digacc18_21 #(
    parameter  int DATA_WIDTH = 18,
    parameter  int ACC_WIDTH  = 21,
    parameter  int MAX_TERMS  = 8,
    parameter  int MODULUS    = 177147,
    localparam int CNT_W      = $clog2(MAX_TERMS) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_digit,
    input  logic                  in_last,
    input  logic                  in_clear,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic [CNT_W-1:0]      out_cnt,
    output logic                  out_forced,
    output logic                  out_err
);

`ifdef DIGACC_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    localparam logic [DATA_WIDTH-1:0] MOD_D   = DATA_WIDTH'(MODULUS);
    localparam logic [CNT_W-1:0]      ONE_CNT = CNT_W'(1);
    localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_TERMS);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic                   emit;
    logic [ACC_WIDTH-1:0]   emit_sum;
    logic [CNT_W-1:0]       emit_cnt;
    logic                   emit_forced;
    logic                   emit_err;

    logic [ACC_WIDTH-1:0]   digit_ext;
    logic [ACC_WIDTH-1:0]   sum;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   term_bad;

    // With the range check disabled RANGE_EN folds the comparator and err flag away.
    assign term_bad  = RANGE_EN && (in_digit >= MOD_D);
    assign digit_ext = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, in_digit};
    assign sum       = acc_q + digit_ext;
    assign cnt_inc   = cnt_q + ONE_CNT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        emit        = 1'b0;
        emit_sum    = '0;
        emit_cnt    = '0;
        emit_forced = 1'b0;
        emit_err    = 1'b0;

        if (in_clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (in_last) begin
                        emit     = 1'b1;
                        emit_sum = digit_ext;
                        emit_cnt = ONE_CNT;
                        emit_err = term_bad;
                    end else begin
                        state_d = ACCUM;
                        acc_d   = digit_ext;
                        cnt_d   = ONE_CNT;
                        err_d   = term_bad;
                    end
                end
                ACCUM: begin
                    if (in_last || (cnt_inc == MAX_CNT)) begin
                        emit        = 1'b1;
                        emit_sum    = sum;
                        emit_cnt    = cnt_inc;
                        emit_forced = !in_last;
                        emit_err    = err_q | term_bad;
                        state_d     = IDLE;
                        acc_d       = '0;
                        cnt_d       = '0;
                        err_d       = 1'b0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_inc;
                        err_d = err_q | term_bad;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    // Output fields update only on emit so they hold between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_cnt    <= '0;
            out_forced <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                out_sum    <= emit_sum;
                out_cnt    <= emit_cnt;
                out_forced <= emit_forced;
                out_err    <= emit_err;
            end
        end
    end

endmodule
